// File: rtl/cfg_chain_loader.sv
// Configuration shift-chain loader: serializes CHAIN_LEN bits MSB-first from a word stream.
// Optional chain-tail readback is enabled by defining CFG_READBACK_EN.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_clk,
    output logic              shift_o,
    input  logic              shift_ret,
    output logic              fab_rst,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int BC_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W = $clog2(WORD_W + 1);
    localparam int DC_W = $clog2(CLK_DIV);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0] LAST_WBIT = WC_W'(WORD_W - 1);
    localparam logic [DC_W-1:0] LAST_DIV  = DC_W'(CLK_DIV - 1);
    localparam logic [DC_W-1:0] RISE_PRE  = DC_W'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state, next_state;
    logic [WORD_W-1:0] shift_buf;
    logic [WORD_W-1:0] buf_shifted;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_bit_cnt;
    logic [DC_W-1:0]   div_cnt;
    logic              period_end;

    assign in_ready    = (state == WAIT_WORD);
    assign period_end  = (state == SHIFT) && (div_cnt == LAST_DIV);
    assign buf_shifted = shift_buf << 1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // The chain-length check wins over the word boundary so a partial last word stops early.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = WAIT_WORD;
            WAIT_WORD:  if (in_valid) next_state = SHIFT;
            SHIFT: begin
                if (period_end) begin
                    if (bit_cnt == LAST_BIT)             next_state = DONE;
                    else if (word_bit_cnt == LAST_WBIT)  next_state = WAIT_WORD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Data changes on cycle 0 of each bit period; shift_clk rises CLK_DIV/2 cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_buf    <= '0;
            bit_cnt      <= '0;
            word_bit_cnt <= '0;
            div_cnt      <= '0;
            shift_clk    <= 1'b0;
            shift_o      <= 1'b0;
            busy         <= 1'b0;
            fab_rst      <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy    <= (next_state == WAIT_WORD) || (next_state == SHIFT);
            fab_rst <= (next_state == WAIT_WORD) || (next_state == SHIFT);
            done    <= (next_state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) bit_cnt <= '0;
                end
                WAIT_WORD: begin
                    if (in_valid) begin
                        shift_buf    <= in_data;
                        shift_o      <= in_data[WORD_W-1];
                        word_bit_cnt <= '0;
                        div_cnt      <= '0;
                    end
                end
                SHIFT: begin
                    if (period_end) begin
                        shift_clk    <= 1'b0;
                        div_cnt      <= '0;
                        shift_buf    <= buf_shifted;
                        bit_cnt      <= bit_cnt + BC_W'(1);
                        word_bit_cnt <= word_bit_cnt + WC_W'(1);
                        if (next_state == SHIFT) shift_o <= buf_shifted[WORD_W-1];
                    end else begin
                        div_cnt <= div_cnt + DC_W'(1);
                        if (div_cnt == RISE_PRE) shift_clk <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] rb_buf;
    logic [WORD_W-1:0] rb_next;
    logic              rb_sample;

    assign rb_sample = (state == SHIFT) && (div_cnt == RISE_PRE);
    assign rb_next   = WORD_W'({rb_buf, shift_ret});

    // Tail is sampled just before shift_clk rises, so it still shows the previous chain contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_buf   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (rb_sample) begin
                rb_buf <= rb_next;
                if (word_bit_cnt == LAST_WBIT) begin
                    rb_data  <= rb_next;
                    rb_valid <= 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    rb_data  <= rb_next << (LAST_WBIT - word_bit_cnt);
                    rb_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_shift_ret;
    assign unused_shift_ret = shift_ret;
    assign rb_data  = '0;
    assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader (CHAIN_LEN=20, WORD_W=8, CLK_DIV=4) with a chain model.
// Readback expectations are checked when CFG_READBACK_EN is defined.
module tb_cfg_chain_loader;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, shift_clk, shift_o, shift_ret;
    logic          fab_rst, busy, done, rb_valid;
    logic [WW-1:0] rb_data;

    logic [CL-1:0] chain = 20'h12345;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    int handshakes = 0;
    int stable = 0;
    logic prev_sclk = 1'b0;
    logic prev_o = 1'b0;
    logic exp_bits[$];
    logic [WW-1:0] exp_rb[$];

    always #5 clk = ~clk;

    assign shift_ret = chain[CL-1];
    always @(posedge shift_clk) chain <= {chain[CL-2:0], shift_o};

    cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .shift_clk(shift_clk), .shift_o(shift_o), .shift_ret(shift_ret),
        .fab_rst(fab_rst), .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops expected bits on every shift_clk rise and expected readback words on rb_valid.
    always @(negedge clk) begin
        if (shift_o !== prev_o) stable = 0;
        else                    stable++;
        if (shift_clk && !prev_sclk) begin
            edges++;
            checkOutput("setup_cycles", stable >= CD / 2, 1);
            checkOutput("fab_rst_at_edge", fab_rst, 1);
            checkOutput("edge_expected", exp_bits.size() > 0, 1);
            if (exp_bits.size() > 0) checkOutput("shift_o", shift_o, exp_bits.pop_front());
        end
        if (in_valid && in_ready) handshakes++;
        if (rb_valid) begin
`ifdef CFG_READBACK_EN
            checkOutput("rb_expected", exp_rb.size() > 0, 1);
            if (exp_rb.size() > 0) checkOutput("rb_data", rb_data, exp_rb.pop_front());
`else
            checkOutput("rb_valid_disabled", rb_valid, 0);
`endif
        end
        prev_sclk = shift_clk;
        prev_o    = shift_o;
    end

    task automatic checkResetValues(input string name);
        checkOutput(name, {in_ready, shift_clk, shift_o, fab_rst, busy, done, rb_valid}, 0);
        checkOutput({name, "_rb_data"}, rb_data, 0);
    endtask

    task automatic sendWord(input logic [WW-1:0] w, input int gap, output bit ok);
        int t = 0;
        in_data = w;
        if (gap == 0) in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        checkOutput("word_accept_wait", in_ready, 1);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        if (gap > 0) begin
            for (int i = 0; i < gap; i++) begin
                checkOutput("gap_shift_clk", shift_clk, 0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2,
                                 input logic [CL-1:0] exp_stream,
                                 input logic [WW-1:0] r0, input logic [WW-1:0] r1, input logic [WW-1:0] r2,
                                 input int gap, input bit poke_start);
        logic [WW-1:0] words[3];
        bit ok;
        int t = 0;
        words = '{w0, w1, w2};
        edges = 0;
        handshakes = 0;
        for (int i = CL - 1; i >= 0; i--) exp_bits.push_back(exp_stream[i]);
        exp_rb.push_back(r0);
        exp_rb.push_back(r1);
        exp_rb.push_back(r2);
        @(posedge clk); #1;
        start = 1'b1;
        in_data = w0;
        if (gap == 0) in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("fab_rst_after_start", fab_rst, 1);
        checkOutput("done_cleared", done, 0);
        for (int k = 0; k < 3; k++) begin
            sendWord(words[k], (k > 0) ? gap : 0, ok);
            if (!ok) break;
            if (k == 0 && poke_start) begin
                @(posedge clk); #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checkOutput("done_reached", done, 1);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("fab_rst_after_done", fab_rst, 0);
        checkOutput("shift_clk_after_done", shift_clk, 0);
        checkOutput("edge_count", edges, CL);
        checkOutput("bits_left", exp_bits.size(), 0);
        checkOutput("handshakes", handshakes, 3);
`ifdef CFG_READBACK_EN
        checkOutput("rb_words_left", exp_rb.size(), 0);
`else
        checkOutput("rb_data_disabled", rb_data, 0);
`endif
        exp_bits.delete();
        exp_rb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetValues("after_reset");

        // Idle with in_valid asserted and no start: nothing may move.
        edges = 0;
        handshakes = 0;
        in_data = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkResetValues("idle");
        end
        checkOutput("idle_edges", edges, 0);
        checkOutput("idle_handshakes", handshakes, 0);
        in_valid = 1'b0;

        applyStimulus(8'hA5, 8'h3C, 8'h96, 20'hA53C9, 8'h12, 8'h34, 8'h50, 0, 1'b0);
        applyStimulus(8'hFF, 8'h00, 8'hF0, 20'hFF00F, 8'hA5, 8'h3C, 8'h90, 0, 1'b1);
        applyStimulus(8'h5A, 8'hC3, 8'h7E, 20'h5AC37, 8'hFF, 8'h00, 8'hF0, 25, 1'b0);

        // Abort a pass with reset just after the fifth shift edge.
        edges = 0;
        exp_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sendWord(8'h81, 0, ok);
        t = 0;
        while (edges < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput("abort_edge_reached", edges >= 5, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("after_abort");
        checkOutput("abort_edges", edges, 5);
        checkOutput("abort_bits_left", exp_bits.size(), 0);
        exp_bits.delete();

        applyStimulus(8'h12, 8'h34, 8'h5F, 20'h12345, 8'h58, 8'h6F, 8'h00, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Bitstream loader that drives the fabric configuration shift chain: the transmitting end of the shift_clk/shift_i/shift_o daisy chain threaded through every flop and LUT cell.
- Accepts configuration words over a valid/ready stream and serializes exactly CHAIN_LEN bits, MSB-first, onto the chain head with a generated shift clock.
- Holds fabric reset asserted while configuring.
- Sits between the bitstream source (host interface or ROM reader) and the fabric top level.

Parameters:
- CHAIN_LEN, 64: total configuration bits in the chain (≥1).
- WORD_W, 8: width of input words (≥1).
- CLK_DIV, 4: clk cycles per shifted bit; even, ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a configuration pass; ignored unless state is IDLE or DONE.
- in_data  input  WORD_W  configuration word, MSB shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- shift_clk  output  1  chain shift clock.
- shift_o  output  1  serial data to chain head (drives the first cell's shift_i).
- shift_ret  input  1  chain tail (last cell's shift_o); used only with CFG_READBACK_EN.
- fab_rst  output  1  fabric reset, held high while configuring.
- busy  output  1  pass in progress.
- done  output  1  sticky completion flag.
- rb_data  output  WORD_W  readback word.
- rb_valid  output  1  one-cycle strobe for rb_data.

Behaviour:
- Reset values: in_ready=0, shift_clk=0, shift_o=0, fab_rst=0, busy=0, done=0, rb_data=0, rb_valid=0, state=IDLE, all counters 0.
- States:
  - IDLE: start → WAIT_WORD; busy=1, fab_rst=1, done=0, bit count=0.
  - WAIT_WORD: in_ready=1 (combinational on state). in_valid&&in_ready loads the word into the shift buffer → SHIFT. shift_clk is held low and shift_o holds its last value.
  - SHIFT: each bit period is CLK_DIV cycles.
    - Cycle 0 of a period: shift_o = current buffer MSB; shift_clk=0.
    - Cycles CLK_DIV/2 .. CLK_DIV-1: shift_clk=1. The rising edge occurs CLK_DIV/2 cycles after the data change (setup = hold = CLK_DIV/2 cycles).
    - End of period: buffer shifts left, bit count increments.
    - After WORD_W bits, or when bit count reaches CHAIN_LEN → WAIT_WORD or DONE respectively.
  - DONE: shift_clk=0, busy=0, fab_rst=0 (deasserted on DONE entry), done=1 held until the next start or rst. start → WAIT_WORD as from IDLE.
- Final partial word: when CHAIN_LEN mod WORD_W = r ≠ 0, only the r MSBs of the last word are shifted; the remaining bits are discarded.
- Total words accepted per pass = ceil(CHAIN_LEN/WORD_W). No word is accepted outside WAIT_WORD.
- start while busy: ignored, no effect.
- start and in_valid in the same cycle in IDLE: the word is not accepted (in_ready=0 in IDLE).
- rst mid-pass: immediate return to reset values. Chain contents are undefined; a new start is required.
- Counters are sized clog2(CHAIN_LEN+1), clog2(WORD_W+1) and clog2(CLK_DIV); no wrap within a pass.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - On each shift_clk rising-edge cycle, shift_ret is sampled into a WORD_W readback buffer, MSB-first. This captures the previous chain contents as the new stream is pushed in.
  - Every WORD_W samples: rb_data = buffer, rb_valid pulses 1 cycle, no backpressure.
  - Final partial group: the r bits are emitted left-aligned and zero-padded, with rb_valid at the last sample.
- Undefined: shift_ret is ignored; rb_data=0, rb_valid=0 constantly.

Test Plan:
- Reset then idle 10 cycles, with in_valid=1 → all outputs at reset values, no word accepted, shift_clk never toggles.
- CHAIN_LEN=16, WORD_W=8, CLK_DIV=4; start, words 0xA5 then 0x3C with in_valid always high → shift_o sequence 1010010100111100. Each bit is stable 2 cycles before the shift_clk rise. Exactly 16 rising edges. fab_rst high from the cycle after start until DONE. done=1 and busy=0 afterwards.
- CHAIN_LEN=20, WORD_W=8; words 0xFF, 0x00, 0xF0 → 20 edges, last 4 bits 1111. Third word's low nibble is never shifted. Exactly 3 handshakes.
- in_valid withheld 25 cycles between words → shift_clk stays 0 during the gap. Bit order is unaffected. Total edges = CHAIN_LEN.
- rst asserted after the 5th shift edge → next cycle all outputs at reset values. A subsequent start runs a full, correct pass.
- CFG_READBACK_EN, CHAIN_LEN=16, bench chain model preloaded with 0x1234 → rb_data 0x12 then 0x34, one rb_valid each. Second pass returns the first pass's data.
